ram_n_clr: RTL and testbench
============================

Name: ram_n_clr

Overview:
Parametrised successor to the fixed 8-word register RAM. Depth is 2**ADDR_WIDTH and word width is DATA_WIDTH. Reads are synchronous and registered, with a valid strobe. After reset, and on request, a hardware sweep clears every location to zero. Serves as the generic data-memory bank for the CPU datapath; RAM64/RAM512-class instances become parameter settings of this block.

Parameters:
DATA_WIDTH, 16, word width in bits
ADDR_WIDTH, 3, address width; DEPTH = 2**ADDR_WIDTH words (default 8)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
address  input  ADDR_WIDTH  word address for read and write
in  input  DATA_WIDTH  write data
load  input  1  write enable, sampled at clk edge
rd_en  input  1  read request, sampled at clk edge
clear  input  1  request a full zero-sweep of the array
out  output  DATA_WIDTH  registered read data
out_valid  output  1  high for one cycle when out carries data from an rd_en
busy  output  1  high while the clear sweep runs; commands are ignored

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values while rst_n=0:
  - state=CLEAR, clr_addr=0
  - busy=1, out=0, out_valid=0
  - The array contents are not reset directly; the sweep zeroes them.
- States: CLEAR, IDLE. All outputs are registered.
- CLEAR:
  - Each edge writes 0 to mem[clr_addr], then clr_addr+1.
  - The edge that writes mem[DEPTH-1] moves the FSM to IDLE and drops busy.
  - Sweep length is exactly DEPTH edges after rst_n rises or after clear is accepted.
  - load, rd_en and clear are ignored.
  - out_valid=0; out holds its last value.
- IDLE, load=1: mem[address] <= in at the edge. Zero latency to storage.
- IDLE, rd_en=1: at the edge, out <= mem[address] and out_valid <= 1. Read latency is 1 cycle.
- IDLE, rd_en=0: out_valid <= 0 and out holds.
- Same-cycle load and rd_en to the same address: write-first. out <= in, and the array is updated.
- Same-cycle load and rd_en to different addresses: both are performed.
- IDLE, clear=1: priority over load and rd_en in the same cycle, which are dropped.
  - Next state is CLEAR with clr_addr=0 and busy=1.
  - out_valid <= 0.
- clr_addr is ADDR_WIDTH bits. The counter stops at DEPTH-1 and never wraps into a second pass.
- clear held high through CLEAR has no effect. Re-asserting it in IDLE starts a new sweep.
- rst_n asserted mid-sweep or mid-read: the sweep restarts from address 0 after release. Partially cleared contents are simply overwritten.
- address/in values X while busy=1 must not corrupt the array.

Decomposition:
- Package ram_pkg holds:
  - the ram_state_t enum (CLEAR, IDLE)
  - default DATA_WIDTH/ADDR_WIDTH constants
  - a DEPTH function of ADDR_WIDTH
- Sub-module ram_clear_seq contains the state register, clr_addr counter and busy generation. It outputs the sweep write-enable and sweep address.
- The top level muxes the sweep port against the user port into the array and owns the out/out_valid registers.

Test Plan (defaults DATA_WIDTH=16, ADDR_WIDTH=3):
1. Reset release: pulse rst_n low, release, count cycles -> busy=1 for exactly 8 edges then 0. After that, rd_en each address 0..7 -> out=0000 with out_valid=1 one cycle after each request.
2. Write then read: load address=0 in=A5A5, load address=1 in=5A5A, then rd_en address 0, then address 1 -> out=A5A5, then out=5A5A, each 1 cycle after rd_en. out_valid drops when rd_en=0.
3. Write-first collision: load=1, rd_en=1, address=2, in=FFFF in one cycle -> next cycle out=FFFF, out_valid=1. A later read of address 2 also returns FFFF.
4. Commands during sweep: assert clear with load=1 address=3 in=1234 the same cycle, then hold load/rd_en high for 8 cycles -> busy for 8 edges, out_valid stays 0. Afterwards address 3 reads 0000 and every address reads 0000.
5. Reset mid-sweep: assert clear, drop rst_n after 4 sweep edges, release -> busy again for a full 8 edges from address 0. All locations read 0000.
6. Parameter sweep: ADDR_WIDTH=6, DATA_WIDTH=32 -> clear lasts 64 edges. Write FFFFFFFF to address 63 and 00000001 to address 0, then read both -> correct data, no aliasing between locations.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared definitions for the ram_n_clr data-memory bank.
//   ram_state_t    : sweep FSM states (CLEAR while zeroing, IDLE when serving commands)
//   DEF_DATA_WIDTH : default word width
//   DEF_ADDR_WIDTH : default address width
//   depth()        : number of words for a given address width
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } ram_state_t;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 3;

  function automatic int depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Zero-sweep sequencer for ram_n_clr.
// Owns the CLEAR/IDLE state register and the sweep address counter.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : sweep request, honoured only in IDLE
//   busy        : high while sweeping; user commands must be ignored
//   sweep_we    : write-enable for the zero write of the current sweep address
//   sweep_addr  : location being zeroed this cycle
//   state       : current FSM state, exported for observation
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  output logic                  busy,
  output logic                  sweep_we,
  output logic [ADDR_WIDTH-1:0] sweep_addr,
  output ram_state_t            state
);

  ram_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // The counter parks on the last address when the sweep ends instead of
  // wrapping; a new sweep explicitly reloads it with zero.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      CLEAR: begin
        if (&clr_addr_q) begin
          state_d = IDLE;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      IDLE: begin
        if (clear) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end
      end
      default: begin
        state_d    = CLEAR;
        clr_addr_d = '0;
      end
    endcase
  end

  assign busy       = (state_q == CLEAR);
  assign sweep_we   = busy;
  assign sweep_addr = clr_addr_q;
  assign state      = state_q;

endmodule

// File: rtl/ram_n_clr.sv
// Parametrised register RAM with registered reads and a hardware zero-sweep.
// Depth is 2**ADDR_WIDTH words of DATA_WIDTH bits.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   address    : word address for load and rd_en
//   in         : write data
//   load       : write enable
//   rd_en      : read request; data appears on out one cycle later
//   clear      : start a zero-sweep of the whole array (IDLE only)
//   out        : registered read data, holds between reads
//   out_valid  : one-cycle strobe marking out as the result of an rd_en
//   busy       : high while the sweep runs; load/rd_en/clear are ignored
// Handshake: no backpressure. A command is taken on any rising edge where
// busy is low; a read's data is valid exactly on the cycle out_valid is high.
module ram_n_clr
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] in,
  input  logic                  load,
  input  logic                  rd_en,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  out_valid,
  output logic                  busy
);

  localparam int DEPTH = depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  sweep_we;
  logic [ADDR_WIDTH-1:0] sweep_addr;
  ram_state_t            state;

  ram_clear_seq #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .busy       (busy),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr),
    .state      (state)
  );

  // clear wins over same-cycle load/rd_en, so it masks both here.
  logic idle;
  logic user_we;
  logic user_re;
  assign idle    = (state == IDLE);
  assign user_we = idle && load && !clear;
  assign user_re = idle && rd_en && !clear;

  // Write-first: a read colliding with a write returns the new data.
  logic [DATA_WIDTH-1:0] rd_data;
  assign rd_data = (user_we) ? in : mem[address];

  // The array has no reset; the post-reset sweep zeroes it. The sweep port
  // is selected purely by sweep_we so user address/data are never used
  // while busy, whatever their value.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[sweep_addr] <= '0;
    end else if (user_we) begin
      mem[address] <= in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= user_re;
      if (user_re) begin
        out <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_ram_n_clr.sv
module tb_ram_n_clr;

  logic        clk;
  logic        rst_n;
  logic [2:0]  address;
  logic [15:0] din;
  logic        load;
  logic        rd_en;
  logic        clear;
  logic [15:0] dout;
  logic        out_valid;
  logic        busy;

  logic [5:0]  b_address;
  logic [31:0] b_din;
  logic        b_load;
  logic        b_rd_en;
  logic        b_clear;
  logic [31:0] b_dout;
  logic        b_out_valid;
  logic        b_busy;

  int checks;
  int failures;

  // reference model: plain arrays of word contents and the last read result
  logic [15:0] model [8];
  logic [15:0] last_out;
  logic [31:0] b_model [64];
  logic [31:0] b_last_out;
  logic [15:0] exp_q [$];
  logic [31:0] b_exp_q [$];

  ram_n_clr dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .address   (address),
    .in        (din),
    .load      (load),
    .rd_en     (rd_en),
    .clear     (clear),
    .out       (dout),
    .out_valid (out_valid),
    .busy      (busy)
  );

  ram_n_clr #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) dut_big (
    .clk       (clk),
    .rst_n     (rst_n),
    .address   (b_address),
    .in        (b_din),
    .load      (b_load),
    .rd_en     (b_rd_en),
    .clear     (b_clear),
    .out       (b_dout),
    .out_valid (b_out_valid),
    .busy      (b_busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic zero_model();
    for (int i = 0; i < 8; i++) model[i] = '0;
    for (int i = 0; i < 64; i++) b_model[i] = '0;
  endtask

  // Counts edges from now until busy falls (bounded).
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      n++;
      if (!busy) break;
    end
  endtask

  // Drives one command cycle on the small instance and checks its result.
  task automatic op(input logic ld, input logic rd, input logic [2:0] a, input logic [15:0] d);
    logic [15:0] exp;
    load = ld; rd_en = rd; address = a; din = d;
    if (rd) begin
      exp = ld ? d : model[a];
      exp_q.push_back(exp);
    end
    if (ld) model[a] = d;
    @(posedge clk); #1;
    load = 1'b0; rd_en = 1'b0;
    if (rd) last_out = exp_q.pop_front();
    checks++;
    if (out_valid !== rd) begin
      failures++;
      $display("FAIL op_valid addr=%0d got=%b want=%b", a, out_valid, rd);
    end
    checks++;
    if (dout !== last_out) begin
      failures++;
      $display("FAIL op_data addr=%0d got=%h want=%h", a, dout, last_out);
    end
  endtask

  task automatic b_op(input logic ld, input logic rd, input logic [5:0] a, input logic [31:0] d);
    logic [31:0] exp;
    b_load = ld; b_rd_en = rd; b_address = a; b_din = d;
    if (rd) begin
      exp = ld ? d : b_model[a];
      b_exp_q.push_back(exp);
    end
    if (ld) b_model[a] = d;
    @(posedge clk); #1;
    b_load = 1'b0; b_rd_en = 1'b0;
    if (rd) b_last_out = b_exp_q.pop_front();
    checks++;
    if (b_out_valid !== rd) begin
      failures++;
      $display("FAIL big_valid addr=%0d got=%b want=%b", a, b_out_valid, rd);
    end
    checks++;
    if (b_dout !== b_last_out) begin
      failures++;
      $display("FAIL big_data addr=%0d got=%h want=%h", a, b_dout, b_last_out);
    end
  endtask

  task automatic read_all();
    for (int i = 0; i < 8; i++) op(1'b0, 1'b1, 3'(i), 16'h0);
  endtask

  // Asserts reset, checks reset values, releases just after an edge.
  task automatic apply_reset();
    load = 0; rd_en = 0; clear = 0; address = 0; din = 0;
    b_load = 0; b_rd_en = 0; b_clear = 0; b_address = 0; b_din = 0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #3;
    last_out = '0;
    b_last_out = '0;
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0 || dout !== 16'h0) begin
      failures++;
      $display("FAIL reset_values busy=%b out_valid=%b out=%h want 1/0/0000", busy, out_valid, dout);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int n;
    apply_reset();
    count_busy(n);
    checks++;
    if (n !== 8) begin
      failures++;
      $display("FAIL reset_sweep_len got=%0d want=8", n);
    end
    zero_model();
    read_all();
  endtask

  task automatic test_write_read();
    op(1'b1, 1'b0, 3'd0, 16'hA5A5);
    op(1'b1, 1'b0, 3'd1, 16'h5A5A);
    op(1'b0, 1'b1, 3'd0, 16'h0);
    op(1'b0, 1'b1, 3'd1, 16'h0);
    op(1'b0, 1'b0, 3'd0, 16'h0);
  endtask

  task automatic test_collision();
    op(1'b1, 1'b1, 3'd2, 16'hFFFF);
    op(1'b0, 1'b0, 3'd0, 16'h0);
    op(1'b0, 1'b1, 3'd2, 16'h0);
    // different-address collision: both happen
    op(1'b1, 1'b1, 3'd4, 16'h1357);
    op(1'b1, 1'b1, 3'd5, 16'h2468);
    op(1'b0, 1'b1, 3'd4, 16'h0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         3'($urandom_range(0, 7)), 16'($urandom));
    end
  endtask

  task automatic test_clear_during();
    int n;
    bit bad_valid;
    clear = 1'b1; load = 1'b1; address = 3'd3; din = 16'h1234;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL clear_accept busy=%b out_valid=%b want 1/0", busy, out_valid);
    end
    n = 0;
    bad_valid = 0;
    rd_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      address = 3'($urandom_range(0, 7));
      din = 16'($urandom);
      @(posedge clk); #1;
      n++;
      if (out_valid !== 1'b0) bad_valid = 1;
      if (!busy) break;
    end
    clear = 1'b0; load = 1'b0; rd_en = 1'b0;
    checks++;
    if (n !== 8) begin
      failures++;
      $display("FAIL clear_sweep_len got=%0d want=8", n);
    end
    checks++;
    if (bad_valid) begin
      failures++;
      $display("FAIL clear_valid got=1 want=0 during sweep");
    end
    checks++;
    if (dout !== last_out) begin
      failures++;
      $display("FAIL clear_out_hold got=%h want=%h", dout, last_out);
    end
    zero_model();
    read_all();
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    for (int i = 0; i < 8; i++) op(1'b1, 1'b0, 3'(i), 16'(16'h1111 * (i + 1)));
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    last_out = '0;
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0 || dout !== 16'h0) begin
      failures++;
      $display("FAIL midsweep_reset busy=%b out_valid=%b out=%h want 1/0/0000", busy, out_valid, dout);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    count_busy(n);
    checks++;
    if (n !== 8) begin
      failures++;
      $display("FAIL midsweep_len got=%0d want=8", n);
    end
    zero_model();
    read_all();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) op(1'b1, 1'b0, 3'(i), 16'($urandom));
    for (int i = 7; i >= 0; i--) op(1'b0, 1'b1, 3'(i), 16'h0);
  endtask

  task automatic test_param();
    int n;
    apply_reset();
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      n++;
      if (!b_busy) break;
    end
    checks++;
    if (n !== 64) begin
      failures++;
      $display("FAIL big_sweep_len got=%0d want=64", n);
    end
    zero_model();
    b_op(1'b1, 1'b0, 6'd63, 32'hFFFF_FFFF);
    b_op(1'b1, 1'b0, 6'd0, 32'h0000_0001);
    b_op(1'b0, 1'b1, 6'd63, 32'h0);
    b_op(1'b0, 1'b1, 6'd0, 32'h0);
    b_op(1'b0, 1'b1, 6'd62, 32'h0);
    b_op(1'b0, 1'b1, 6'd1, 32'h0);
    b_op(1'b0, 1'b1, 6'd31, 32'h0);
    for (int i = 0; i < 60; i++) begin
      b_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           6'($urandom_range(0, 63)), 32'($urandom));
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b1;
    last_out = '0;
    b_last_out = '0;
    zero_model();
    test_reset();
    test_write_read();
    test_collision();
    test_random();
    test_clear_during();
    test_back_to_back();
    test_reset_mid_sweep();
    test_param();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
